// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, widths and forwarding helper for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;
  localparam logic [1:0] FWD_REG = 2'b00, FWD_EXALU = 2'b01, FWD_MEMALU = 2'b10, FWD_MEMLD = 2'b11;
  typedef enum logic {MS_IDLE = 1'b0, MS_WAIT = 1'b1} mem_state_t;
  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic memop;
    logic [REG_W-1:0] rd;
  } shadow_t;
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input shadow_t ex, input shadow_t mem);
    return (ex.wreg && ex.rd != '0 && ex.rd == src && !ex.m2reg) ? FWD_EXALU :
           (mem.wreg && mem.rd != '0 && mem.rd == src) ? (mem.m2reg ? FWD_MEMLD : FWD_MEMALU) : FWD_REG;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage hazard inputs, dmem handshake and pipeline control outputs
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wmem, id_taken, dmem_ack;
  logic [1:0] fwda, fwdb;
  logic stall, bubble_idex, flush_ifid, freeze, dmem_req, mem_err;
  modport master(
    output id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wmem, id_taken, dmem_ack,
    input fwda, fwdb, stall, bubble_idex, flush_ifid, freeze, dmem_req, mem_err
  );
  modport slave(
    input id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wmem, id_taken, dmem_ack,
    output fwda, fwdb, stall, bubble_idex, flush_ifid, freeze, dmem_req, mem_err
  );
endinterface

// File: rtl/dmem_wait_fsm.sv
// dmem_wait_fsm: data-memory req/ack wait tracker with sticky ack-timeout error
module dmem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic memop,
  input  logic ack,
  output logic req,
  output logic freeze,
  output logic mem_err
);
  mem_state_t state;
  logic [3:0] wait_cnt;
  always_comb begin
    req = (state == MS_WAIT) | memop;
    freeze = req & ~ack;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= MS_IDLE;
      wait_cnt <= '0;
      mem_err <= 1'b0;
    end else if (state == MS_IDLE) begin
      if (memop & ~ack) begin
        state <= MS_WAIT;
        wait_cnt <= 4'd1;
      end
    end else begin
      if (ack) state <= MS_IDLE;
      if (wait_cnt != 4'hf) wait_cnt <= wait_cnt + 4'd1;
      if (wait_cnt == 4'(MEM_TIMEOUT) && !ack) mem_err <= 1'b1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, load-use stall, branch flush and dmem freeze; PIPE_PERF_CNT_EN adds stall/freeze/flush counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit DELAY_SLOT = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clock,
  input logic reset,
  pipe_hazard_ctrl_if.slave p
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  shadow_t ex, mem;
  logic lu;
  dmem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clock(clock),
    .reset(reset),
    .memop(mem.memop),
    .ack(p.dmem_ack),
    .req(p.dmem_req),
    .freeze(p.freeze),
    .mem_err(p.mem_err)
  );
  always_comb begin
    lu = ex.wreg & ex.m2reg & (ex.rd != '0) &
         ((p.id_use_rs & (p.id_rs == ex.rd)) | (p.id_use_rt & (p.id_rt == ex.rd)));
    p.fwda = fwd_sel(p.id_rs, ex, mem);
    p.fwdb = fwd_sel(p.id_rt, ex, mem);
    p.stall = lu & ~p.freeze;
    p.bubble_idex = lu & ~p.freeze;
    // a taken branch whose operands are still being loaded waits for the stall to clear
    p.flush_ifid = ~DELAY_SLOT & p.id_taken & ~lu & ~p.freeze;
  end
  always_ff @(posedge clock)
    if (reset) begin
      ex <= '0;
      mem <= '0;
    end else if (!p.freeze) begin
      mem <= ex;
      ex <= p.bubble_idex ? '0 : shadow_t'{wreg: p.id_wreg, m2reg: p.id_m2reg,
                                           memop: p.id_wmem | p.id_m2reg, rd: p.id_rd};
    end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clock)
    if (reset) begin
      stall_cnt <= '0;
      freeze_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(p.stall);
      freeze_cnt <= freeze_cnt + CNT_W'(p.freeze);
      flush_cnt <= flush_cnt + CNT_W'(p.flush_ifid);
    end
`endif
endmodule
